// File: rtl/trace_pkg.sv
// Shared types for the retire trace buffer: record kinds, the 71-bit trace
// record carried through the FIFO, and the control FSM state encoding.
package trace_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned KIND_W = 3;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [KIND_W-1:0] {
        KIND_NOP   = 3'd0,
        KIND_REG   = 3'd1,
        KIND_LOAD  = 3'd2,
        KIND_STORE = 3'd3,
        KIND_HALT  = 3'd4
    } rec_kind_e;

    // kind(3) + inum(16) + pc(16) + regn(4) + value(16) + addr(16) = 71 bits
    typedef struct packed {
        rec_kind_e           kind;
        logic [DATA_W-1:0]   inum;
        logic [DATA_W-1:0]   pc;
        logic [REG_W-1:0]    regn;
        logic [DATA_W-1:0]   value;
        logic [DATA_W-1:0]   addr;
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_DONE      = 2'd3
    } fsm_state_e;

    // Commit-cycle classification, highest priority first.
    function automatic rec_kind_e classify(input logic is_halt,
                                           input logic reg_write,
                                           input logic mem_read,
                                           input logic mem_write);
        rec_kind_e k;
        if (is_halt)                    k = KIND_HALT;
        else if (reg_write && mem_read) k = KIND_LOAD;
        else if (reg_write)             k = KIND_REG;
        else if (mem_write)             k = KIND_STORE;
        else                            k = KIND_NOP;
        return k;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous DEPTH x trace_rec_t FIFO.
// Ports: clk, rst_n; push/wdata write side; pop read side; rdata_c is the head
// record (all zero when empty); full_c/empty_c status. A push while full is
// accepted only when a pop happens in the same cycle.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  trace_rec_t wdata,
    input  logic       pop,
    output trace_rec_t rdata_c,
    output logic       full_c,
    output logic       empty_c
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    trace_rec_t         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               do_push_c, do_pop_c;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop_c  = pop && !empty_c;
    assign do_push_c = push && (!full_c || do_pop_c);

    assign rdata_c = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire-side trace monitor. Samples the per-cycle commit signals, builds one
// numbered trace record per retired instruction, buffers records in a FIFO and
// drains them over a valid/ready port.
// Inputs : clk, rst_n (async, active-low), pc, inst, reg_write, write_reg,
//          write_data, mem_read, mem_write, mem_addr, mem_data, hlt, rec_ready.
// Outputs: rec_valid + rec_{kind,inum,pc,value,addr,reg} head record,
//          inst_count, cycle_count, halted, done, overflow, timeout.
// Optional: RETIRE_TRACE_WATCHDOG_EN compiles in the CYCLE_LIMIT watchdog;
//           without it timeout is tied to 0.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CYCLE_LIMIT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       pc,
    input  logic [15:0]       inst,
    input  logic              reg_write,
    input  logic [3:0]        write_reg,
    input  logic [15:0]       write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_data,
    input  logic              hlt,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [2:0]        rec_kind,
    output logic [15:0]       rec_inum,
    output logic [15:0]       rec_pc,
    output logic [15:0]       rec_value,
    output logic [15:0]       rec_addr,
    output logic [3:0]        rec_reg,
    output logic [31:0]       inst_count,
    output logic [31:0]       cycle_count,
    output logic              halted,
    output logic              done,
    output logic              overflow,
    output logic              timeout
);

    fsm_state_e         state_q, state_d;
    trace_rec_t         pend_q, pend_d;
    trace_rec_t         cap_c, push_rec_c, head_c;
    logic [CNT_W-1:0]   inst_count_q, inst_count_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic               halted_q, halted_d;
    logic               overflow_q, overflow_d;
    logic               push_c, pop_c, full_c, empty_c;
    logic               wd_hit_c, halt_c;
    logic               inst_unused_c;

    // The instruction word is not part of the record.
    assign inst_unused_c = ^inst;

    assign pop_c = !empty_c && rec_ready;

`ifdef RETIRE_TRACE_WATCHDOG_EN
    logic timeout_q, timeout_d;

    assign wd_hit_c = (cycle_count_q >= CNT_W'(CYCLE_LIMIT));

    // A genuine HLT in the same cycle takes precedence over the watchdog.
    always_comb begin
        timeout_d = timeout_q;
        if (state_q == ST_RUN && wd_hit_c && !hlt) timeout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout_q <= 1'b0;
        else        timeout_q <= timeout_d;
    end

    assign timeout = timeout_q;
`else
    localparam int unsigned CYCLE_LIMIT_UNUSED = CYCLE_LIMIT;

    assign wd_hit_c = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign halt_c = hlt || wd_hit_c;

    // Build this cycle's record; fields not used by the kind stay zero.
    always_comb begin
        cap_c      = '0;
        cap_c.kind = classify(halt_c, reg_write, mem_read, mem_write);
        cap_c.inum = inst_count_q[DATA_W-1:0];
        cap_c.pc   = pc;
        case (cap_c.kind)
            KIND_REG: begin
                cap_c.regn  = write_reg;
                cap_c.value = write_data;
            end
            KIND_LOAD: begin
                cap_c.regn  = write_reg;
                cap_c.value = write_data;
                cap_c.addr  = mem_addr;
            end
            KIND_STORE: begin
                cap_c.value = mem_data;
                cap_c.addr  = mem_addr;
            end
            KIND_HALT: begin
                if (!hlt) cap_c.value = 16'hDEAD;
            end
            default: ;
        endcase
    end

    // Control FSM next-state, counters and flags.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        push_c        = 1'b0;
        push_rec_c    = cap_c;
        inst_count_d  = inst_count_q;
        cycle_count_d = cycle_count_q;
        halted_d      = halted_q;
        overflow_d    = overflow_q;
        case (state_q)
            ST_RUN: begin
                cycle_count_d = cycle_count_q + CNT_W'(1);
                inst_count_d  = inst_count_q + CNT_W'(1);
                if (halt_c) begin
                    if (!full_c || pop_c) begin
                        push_c   = 1'b1;
                        halted_d = 1'b1;
                        state_d  = ST_DRAIN;
                    end else begin
                        pend_d  = cap_c;
                        state_d = ST_HALT_PEND;
                    end
                end else if (!full_c || pop_c) begin
                    push_c = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            ST_HALT_PEND: begin
                cycle_count_d = cycle_count_q + CNT_W'(1);
                push_rec_c    = pend_q;
                if (!full_c || pop_c) begin
                    push_c   = 1'b1;
                    halted_d = 1'b1;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (empty_c) state_d = ST_DONE;
            end
            ST_DONE: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pend_q        <= '0;
            inst_count_q  <= '0;
            cycle_count_q <= '0;
            halted_q      <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            inst_count_q  <= inst_count_d;
            cycle_count_q <= cycle_count_d;
            halted_q      <= halted_d;
            overflow_q    <= overflow_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .wdata   (push_rec_c),
        .pop     (pop_c),
        .rdata_c (head_c),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    assign rec_valid   = !empty_c;
    assign rec_kind    = head_c.kind;
    assign rec_inum    = head_c.inum;
    assign rec_pc      = head_c.pc;
    assign rec_reg     = head_c.regn;
    assign rec_value   = head_c.value;
    assign rec_addr    = head_c.addr;
    assign inst_count  = inst_count_q;
    assign cycle_count = cycle_count_q;
    assign halted      = halted_q;
    assign overflow    = overflow_q;
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_retire_trace_buffer.sv
`timescale 1ns/1ps
module tb_retire_trace_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned LIMIT = 100;

    logic        clk, rst_n;
    logic [15:0] pc, inst, write_data, mem_addr, mem_data;
    logic        reg_write, mem_read, mem_write, hlt, rec_ready;
    logic [3:0]  write_reg, rec_reg;
    logic        rec_valid, halted, done, overflow, timeout;
    logic [2:0]  rec_kind;
    logic [15:0] rec_inum, rec_pc, rec_value, rec_addr;
    logic [31:0] inst_count, cycle_count;

    retire_trace_buffer #(.DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .hlt(hlt),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
        .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_value(rec_value),
        .rec_addr(rec_addr), .rec_reg(rec_reg), .inst_count(inst_count),
        .cycle_count(cycle_count), .halted(halted), .done(done),
        .overflow(overflow), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hlt, rw, mr, mw, rdy;
        logic [3:0]  wr;
        logic [15:0] pc, wd, ad, md;
        logic [2:0]  e_kind;
        logic [3:0]  e_reg;
        logic [15:0] e_value, e_addr;
    } vec_t;

    typedef struct {
        logic [2:0]  kind;
        logic [15:0] inum, pc;
        logic [3:0]  regn;
        logic [15:0] value, addr;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_bad = 0;

    // Reference model state
    logic [31:0] m_inst, m_cyc;
    int          m_occ;
    bit          m_run, m_pend, m_halted, m_done, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic h, rw, mr, mw, input logic [3:0] wr,
                                input logic [15:0] p, wd, ad, md, input logic rdy,
                                input logic [2:0] ek, input logic [3:0] er,
                                input logic [15:0] ev, ea);
        vec_t v;
        v.hlt = h; v.rw = rw; v.mr = mr; v.mw = mw; v.wr = wr; v.pc = p;
        v.wd = wd; v.ad = ad; v.md = md; v.rdy = rdy;
        v.e_kind = ek; v.e_reg = er; v.e_value = ev; v.e_addr = ea;
        return v;
    endfunction

    function automatic vec_t nop(input logic [15:0] p, input logic rdy);
        return mk(0, 0, 0, 0, 4'd0, p, 16'h0, 16'h0, 16'h0, rdy, 3'd0, 4'd0, 16'h0, 16'h0);
    endfunction

    // Busy commit activity that must be ignored once halted.
    function automatic vec_t junk(input logic rdy);
        return mk(1, 1, 1, 1, 4'hA, 16'hEEEE, 16'hBEEF, 16'hF00D, 16'hC0DE, rdy,
                  3'd1, 4'hA, 16'hBEEF, 16'h0);
    endfunction

    task automatic model_reset();
        m_inst = 0; m_cyc = 0; m_occ = 0;
        m_run = 1; m_pend = 0; m_halted = 0; m_done = 0; m_ovf = 0;
        sbq.delete();
    endtask

    // Drive one commit cycle, advance the model, then check counters/flags.
    task automatic step(input vec_t v);
        exp_t e;
        bit   pop, hl, halted0;
        int   occ0;
        pc = v.pc; inst = ~v.pc; hlt = v.hlt; reg_write = v.rw; mem_read = v.mr;
        mem_write = v.mw; write_reg = v.wr; write_data = v.wd; mem_addr = v.ad;
        mem_data = v.md; rec_ready = v.rdy;
        occ0 = m_occ; halted0 = m_halted;
        pop = v.rdy && (occ0 > 0);
        if (halted0 && occ0 == 0) m_done = 1;
        if (m_run || m_pend) m_cyc++;
        if (m_run) begin
            e = '{v.e_kind, m_inst[15:0], v.pc, v.e_reg, v.e_value, v.e_addr};
            m_inst++;
            hl = (v.e_kind == 3'd4);
            if (occ0 < DEPTH || pop) begin
                sbq.push_back(e);
                m_occ++;
                if (hl) begin m_run = 0; m_halted = 1; end
            end else if (hl) begin
                sbq.push_back(e);
                m_run = 0; m_pend = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (m_pend && pop) begin
            m_occ++; m_pend = 0; m_halted = 1;
        end
        if (pop) m_occ--;
        @(posedge clk); #1;
        chk("inst_count", inst_count, m_inst);
        chk("cycle_count", cycle_count, m_cyc);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("done", 32'(done), 32'(m_done));
        chk("rec_valid", 32'(rec_valid), 32'(m_occ > 0));
    endtask

    task automatic check_cleared();
        chk("rst rec_valid", 32'(rec_valid), 32'd0);
        chk("rst inst_count", inst_count, 32'd0);
        chk("rst cycle_count", cycle_count, 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst timeout", 32'(timeout), 32'd0);
        chk("rst rec_pc", 32'(rec_pc), 32'd0);
        chk("rst rec_kind", 32'(rec_kind), 32'd0);
    endtask

    // Asynchronous 1 ns reset pulse in mid-cycle.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check_cleared();
        rst_n = 1'b1;
        model_reset();
    endtask

    // Scoreboard: compare the head record whenever a pop is about to occur.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && rec_valid && rec_ready) begin
            if (sbq.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_record: got inum 0x%0h kind %0d, want none", rec_inum, rec_kind);
            end else begin
                e = sbq.pop_front();
                chk("rec_kind", 32'(rec_kind), 32'(e.kind));
                chk("rec_inum", 32'(rec_inum), 32'(e.inum));
                chk("rec_pc", 32'(rec_pc), 32'(e.pc));
                chk("rec_reg", 32'(rec_reg), 32'(e.regn));
                chk("rec_value", 32'(rec_value), 32'(e.value));
                chk("rec_addr", 32'(rec_addr), 32'(e.addr));
            end
        end
    end

    initial begin : global_bound
        #100000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "bench time limit expired");
    end

    vec_t tbl[8];
    int   k;

    initial begin
        // hlt rw mr mw wr pc wd addr md rdy | kind reg value addr
        tbl[0] = mk(0,1,0,0,4'd3,16'h0000,16'h1234,16'h0000,16'h0000,1, 3'd1,4'd3,16'h1234,16'h0000);
        tbl[1] = mk(0,1,1,0,4'd5,16'h0002,16'h00AA,16'h0040,16'h0000,1, 3'd2,4'd5,16'h00AA,16'h0040);
        tbl[2] = mk(0,0,0,1,4'd9,16'h0004,16'hBBBB,16'h0042,16'h5555,1, 3'd3,4'd0,16'h5555,16'h0042);
        tbl[3] = mk(0,0,0,0,4'd2,16'h0006,16'hFFFF,16'h1111,16'h2222,1, 3'd0,4'd0,16'h0000,16'h0000);
        tbl[4] = mk(0,1,0,1,4'd7,16'h0008,16'h0BEE,16'h0099,16'h0077,1, 3'd1,4'd7,16'h0BEE,16'h0000);
        tbl[5] = mk(0,0,1,0,4'd1,16'h000A,16'h3333,16'h0010,16'h4444,1, 3'd0,4'd0,16'h0000,16'h0000);
        tbl[6] = mk(0,1,1,1,4'hF,16'h000C,16'hCAFE,16'h8000,16'h9999,1, 3'd2,4'hF,16'hCAFE,16'h8000);
        tbl[7] = mk(1,1,1,1,4'd4,16'h000E,16'h7777,16'h6666,16'h5555,1, 3'd4,4'd0,16'h0000,16'h0000);

        rst_n = 1'b0; pc = 0; inst = 0; hlt = 0; reg_write = 0; mem_read = 0;
        mem_write = 0; write_reg = 0; write_data = 0; mem_addr = 0; mem_data = 0;
        rec_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared();
        rst_n = 1'b1;
        model_reset();

        // Classification table, consumer always ready, ends in HALT.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i]);
            if (i == 0) begin
                chk("first rec_kind", 32'(rec_kind), 32'd1);
                chk("first rec_inum", 32'(rec_inum), 32'd0);
                chk("first rec_value", 32'(rec_value), 32'h1234);
            end
        end
        step(junk(1));
        step(junk(1));
        step(junk(1));
        chk("table sb_empty", 32'(sbq.size()), 32'd0);

        // Reset mid-run with buffered records.
        pulse_reset();
        for (int i = 0; i < 3; i++)
            step(mk(0,1,0,0,4'd1,16'h0020 + 16'(i),16'h0100 + 16'(i),16'h0,16'h0,0,
                    3'd1,4'd1,16'h0100 + 16'(i),16'h0));
        pulse_reset();

        // Overflow: 10 NOPs with no consumer, then drain while still retiring.
        for (int i = 0; i < 10; i++) step(nop(16'h0100 + 16'(i), 0));
        chk("held rec_inum", 32'(rec_inum), 32'd0);
        chk("held rec_pc", 32'(rec_pc), 32'h0100);
        for (int i = 0; i < 8; i++) step(nop(16'h0200 + 16'(i), 1));

        // Halt while full: parks in HALT_PEND until a slot frees.
        step(mk(1,0,0,0,4'd0,16'h0300,16'h0,16'h0,16'h0,0, 3'd4,4'd0,16'h0,16'h0));
        step(junk(0));
        step(junk(0));
        k = 0;
        while (!done && k < 20) begin
            step(junk(1));
            k++;
        end
        chk("halt_full done", 32'(done), 32'd1);
        chk("halt_full sb_empty", 32'(sbq.size()), 32'd0);
        step(junk(1));

        // DONE is left only through reset.
        pulse_reset();
        step(tbl[0]);
        step(nop(16'h0400, 1));

`ifdef RETIRE_TRACE_WATCHDOG_EN
        pulse_reset();
        for (int i = 0; i < int'(LIMIT); i++) step(nop(16'(i), 1));
        chk("wd timeout_before", 32'(timeout), 32'd0);
        step(mk(0,0,0,0,4'd0,16'h0500,16'h0,16'h0,16'h0,1, 3'd4,4'd0,16'hDEAD,16'h0));
        chk("wd timeout", 32'(timeout), 32'd1);
        k = 0;
        while (!done && k < 10) begin
            step(junk(1));
            k++;
        end
        chk("wd done", 32'(done), 32'd1);
        chk("wd sb_empty", 32'(sbq.size()), 32'd0);
`else
        chk("timeout tied", 32'(timeout), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
